// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential signed BCD-to-binary converter (reverse double-dabble)
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 11
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  neg,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      value,
  output logic                  ovf,
  output logic                  bad_digit
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (BW > 2) ? $clog2(BW) : 1;
  localparam logic [BW:0] POS_LIM = (BW+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic [BW:0] NEG_LIM = (BW+1)'(2 ** (OUT_W - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_FINISH
  } state_t;

  state_t            state_q;
  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     bin_q;
  logic [CW-1:0]     cnt_q;
  logic              sign_q;
  logic              bad_q;
  logic              busy_q;
  logic              done_q;
  logic [OUT_W-1:0]  value_q;
  logic              ovf_q;
  logic              bad_digit_q;

  logic              nib_bad_d;
  logic [2*BW-1:0]   sh_cat_d;
  logic [BW-1:0]     sh_bcd_d;
  logic [BW-1:0]     sh_bin_d;
  logic [BW:0]       mag_ext_d;
  logic [OUT_W-1:0]  mag_lo_d;
  logic [OUT_W-1:0]  sat_val_d;
  logic              sat_ovf_d;

  always_comb begin
    nib_bad_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] > 4'd9) nib_bad_d = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then pull each digit >= 8 back by 3.
  always_comb begin
    sh_cat_d = {bcd_q, bin_q} >> 1;
    sh_bcd_d = sh_cat_d[2*BW-1:BW];
    sh_bin_d = sh_cat_d[BW-1:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_bcd_d[4*i +: 4] >= 4'd8) sh_bcd_d[4*i +: 4] = sh_bcd_d[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    mag_ext_d = {1'b0, bin_q};
    mag_lo_d  = bin_q[OUT_W-1:0];
    sat_ovf_d = 1'b0;
    sat_val_d = mag_lo_d;
    if (!sign_q) begin
      if (mag_ext_d > POS_LIM) begin
        sat_ovf_d = 1'b1;
        sat_val_d = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end else begin
      if (mag_ext_d > NEG_LIM) begin
        sat_ovf_d = 1'b1;
        sat_val_d = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        sat_val_d = ~mag_lo_d + 1'b1;
      end
    end
  end

  // A bad digit is flagged in CHECK and reported through FINISH, giving done two edges after start.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      bcd_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      bad_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      value_q     <= '0;
      ovf_q       <= 1'b0;
      bad_digit_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            bcd_q   <= bcd_in;
            sign_q  <= neg;
            bin_q   <= '0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          cnt_q <= '0;
          if (nib_bad_d) begin
            bad_q   <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_q <= sh_bcd_d;
          bin_q <= sh_bin_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(BW - 1)) state_q <= S_FINISH;
        end
        S_FINISH: begin
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          bad_digit_q <= bad_q;
          if (bad_q) begin
            ovf_q <= 1'b0;
          end else begin
            value_q <= sat_val_d;
            ovf_q   <= sat_ovf_d;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign value     = value_q;
  assign ovf       = ovf_q;
  assign bad_digit = bad_digit_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - directed self-checking bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        neg;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [10:0] value;
  logic        ovf;
  logic        bad_digit;

  int checks;
  int failures;

  bcd_to_bin_seq #(.DIGITS(4), .OUT_W(11)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .neg       (neg),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .value     (value),
    .ovf       (ovf),
    .bad_digit (bad_digit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Start on edge 0, optionally re-pulse start before edge glitch_at, wait for done.
  task automatic run_conv(input string tag, input logic [15:0] bcd, input logic sgn,
                          input int exp_edge, input logic [10:0] exp_val,
                          input logic exp_ovf, input logic exp_bad, input int glitch_at);
    int   n;
    logic seen;
    bcd_in = bcd;
    neg    = sgn;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bcd_in = 16'hFFFF;
    neg    = ~sgn;
    chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (n + 1 == glitch_at) start = 1'b1;
      tick();
      n++;
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    chk({tag, "_edge"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_edge));
    chk({tag, "_value"}, 32'(value), 32'(exp_val));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    chk({tag, "_bad"}, 32'(bad_digit), 32'(exp_bad));
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) cnt++;
    end
  endtask

  initial begin
    int ndone;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    neg      = 1'b0;
    bcd_in   = 16'h0000;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_bad", 32'(bad_digit), 32'd0);
    reset_n = 1'b1;
    tick();

    run_conv("t1_0123", 16'h0123, 1'b0, 18, 11'h07B, 1'b0, 1'b0, 0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_hold", 32'(value), 32'h07B);

    run_conv("t2_n1024", 16'h1024, 1'b1, 18, 11'h400, 1'b0, 1'b0, 0);
    // back-to-back: next starts are asserted in the done cycle
    run_conv("t3_p1024", 16'h1024, 1'b0, 18, 11'h3FF, 1'b1, 1'b0, 0);
    run_conv("t3_n9999", 16'h9999, 1'b1, 18, 11'h400, 1'b1, 1'b0, 0);
    run_conv("t4_bad", 16'h0A05, 1'b0, 2, 11'h400, 1'b0, 1'b1, 0);
    run_conv("tx_n0001", 16'h0001, 1'b1, 18, 11'h7FF, 1'b0, 1'b0, 0);
    run_conv("tx_p1023", 16'h1023, 1'b0, 18, 11'h3FF, 1'b0, 1'b0, 0);

    // reset at edge 10 of a conversion
    bcd_in = 16'h0999;
    neg    = 1'b0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset_n = 1'b0;
    tick();
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_value", 32'(value), 32'd0);
    chk("t6_rst_ovf", 32'(ovf), 32'd0);
    chk("t6_rst_bad", 32'(bad_digit), 32'd0);
    reset_n = 1'b1;
    count_dones(25, ndone);
    chk("t6_no_done", 32'(ndone), 32'd0);
    run_conv("t6_0999", 16'h0999, 1'b0, 18, 11'h3E7, 1'b0, 1'b0, 0);

    run_conv("t5_glitch", 16'h0000, 1'b1, 18, 11'h000, 1'b0, 1'b0, 5);
    count_dones(25, ndone);
    chk("t5_single_done", 32'(ndone), 32'd0);
    chk("t5_hold", 32'(value), 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
